controlador_display: RTL
========================

CONTROLADOR_DISPLAY -- requirements
Module: controlador_display

Interface
REQ-001 SHALL have parameter DIV, default 50000, SHOW-phase length in clock cycles (>=1).
REQ-002 SHALL have parameter BLANK_CYC, default 500, BLANK-phase length in clock cycles (>=1).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  write request for one digit value.
REQ-006 SHALL have port wr_ready  output  1  shadow bank accepts a write this cycle.
REQ-007 SHALL have port wr_addr  input  2  target digit 0..3.
REQ-008 SHALL have port wr_data  input  3  digit value 0..7.
REQ-009 SHALL have port wr_en  input  1  digit enable written with value (0 = digit blanked).
REQ-010 SHALL have port atualiza  input  1  single-cycle commit request, shadow to active bank.
REQ-011 SHALL have port an  output  4  digit select, active-low, one-hot-low or all ones.
REQ-012 SHALL have port seg  output  7  segment drive, active-low, same encoding as the team's 3-bit decoder.
REQ-013 SHALL have port inicio_quadro  output  1  one-cycle pulse on entry to BLANK of digit 0.

Function
REQ-014 SHALL hold shadow and active banks, each 4 x {value[2:0], enable}.
REQ-015 SHALL accept a write when wr_valid && wr_ready at a rising edge, updating shadow[wr_addr] only.
REQ-016 SHALL set a pending flag on atualiza when no commit is pending; atualiza while pending SHALL be ignored.
REQ-017 SHALL drive wr_ready = !pending; writes attempted while pending SHALL be dropped and leave shadow unchanged.
REQ-018 SHALL accept a write and atualiza arriving in the same cycle (pending was 0), with that write included in the commit.
REQ-019 SHALL run FSM states BLANK and SHOW, with a digit index d (2 bits) and a phase counter.
REQ-020 SHALL make BLANK last exactly BLANK_CYC cycles, then enter SHOW with the same d.
REQ-021 SHALL make SHOW last exactly DIV cycles, then enter BLANK with d = d+1 mod 4 (3 wraps to 0).
REQ-022 SHALL, in BLANK, drive an = 4'b1111 and seg = 7'b1111111.
REQ-023 SHALL, in SHOW, drive an with bit d low and the others high.
REQ-024 SHALL, in SHOW, drive seg = decode(active[d].value) when active[d].enable = 1, else 7'b1111111.
REQ-025 SHALL copy shadow to active and clear pending on the same edge that enters BLANK with d = 0, if pending was 1.
REQ-026 SHALL assert inicio_quadro during the first cycle of BLANK with d = 0, including the first cycle after reset release.
REQ-027 SHALL derive an, seg and wr_ready combinationally from registered state, with no extra output latency.
REQ-028 SHALL complete a full frame in exactly 4*(DIV+BLANK_CYC) cycles.

Reset
REQ-029 SHALL, on resetn low, asynchronously enter BLANK, d = 0, counter = 0, pending = 0, and clear both banks (value 0, enable 0).
REQ-030 SHALL drive an = 4'b1111, seg = 7'b1111111, wr_ready = 1 and inicio_quadro = 0 while in reset.
REQ-031 SHALL discard any pending commit on reset asserted mid-frame; after release, operation SHALL restart from REQ-026.

Structure
REQ-032 SHALL place the state encoding (BLANK, SHOW), NUM_DIGITS = 4 and the blank pattern 7'b1111111 in a shared package.
REQ-033 SHALL instantiate the existing decodificador as its one sub-module, fed from active[d].value.

Verification (DIV=4, BLANK_CYC=2)
REQ-034 SHALL check: reset release with no writes -> an cycles 1111,1111,1110x4,1111x2,1101x4...; seg = 7'b1111111 throughout; inicio_quadro every 24 cycles.
REQ-035 SHALL check: write addr0=3 with en=1, then atualiza -> from the next frame start, seg = 7'b0110000 while an = 1110; previous frame unchanged.
REQ-036 SHALL check: write, then atualiza, then a write of addr1=5 while pending -> wr_ready = 0 and the write is dropped; after commit, digit 1 shows its old value.
REQ-037 SHALL check: write addr2=6 and atualiza in the same cycle -> the value is committed, and seg = 7'b0000010 at an = 1011.
REQ-038 SHALL check: write addr3=7 with en=0, then commit -> seg = 7'b1111111 at an = 0111.
REQ-039 SHALL check: resetn pulsed low during SHOW of d = 2 with commit pending -> outputs blank immediately, pending = 0, active bank cleared, restart at d = 0.

Source files
------------

// File: rtl/controlador_display_pkg.sv
// Shared types and constants for the multiplexed 4-digit display controller.
package controlador_display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;

  typedef struct packed {
    logic [2:0] value;
    logic       enable;
  } digit_t;

endpackage

// File: rtl/decodificador.sv
// 3-bit value to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module decodificador (
  input  logic [2:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (value)
      3'd0: seg = 7'b1000000;
      3'd1: seg = 7'b1111001;
      3'd2: seg = 7'b0100100;
      3'd3: seg = 7'b0110000;
      3'd4: seg = 7'b0011001;
      3'd5: seg = 7'b0010010;
      3'd6: seg = 7'b0000010;
      3'd7: seg = 7'b1111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/controlador_display.sv
// Time-multiplexed 4-digit display driver with double-buffered digit banks;
// the shadow bank is committed to the active bank only at frame start.
module controlador_display
  import controlador_display_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [2:0] wr_data,
  input  logic       wr_en,
  input  logic       atualiza,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       inicio_quadro
);

  localparam int MAX_CYC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state, state_nxt;
  logic [1:0]       d, d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             frame_edge;

  digit_t shadow [NUM_DIGITS];
  digit_t active [NUM_DIGITS];
  logic   pending;
  logic [6:0] seg_dec;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= BLANK;
      d     <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      d     <= d_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    d_nxt      = d;
    cnt_nxt    = cnt + 1'b1;
    frame_edge = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt  = BLANK;
          cnt_nxt    = '0;
          d_nxt      = d + 1'b1;
          frame_edge = (d == 2'd3);
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A commit wins over a new atualiza on the frame edge; writes are blocked while pending.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (frame_edge && pending) begin
        pending <= 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
      end else if (atualiza && !pending) begin
        pending <= 1'b1;
      end
      if (wr_valid && wr_ready) begin
        shadow[wr_addr] <= '{value: wr_data, enable: wr_en};
      end
    end
  end

  decodificador u_decodificador (
    .value (active[d].value),
    .seg   (seg_dec)
  );

  assign wr_ready      = !pending;
  assign an            = (state == SHOW) ? ~(4'b0001 << d) : 4'b1111;
  assign seg           = ((state == SHOW) && active[d].enable) ? seg_dec : SEG_BLANK;
  assign inicio_quadro = resetn && (state == BLANK) && (d == 2'd0) && (cnt == '0);

endmodule
